// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int LEN_W         = 16;
    localparam int MEM_BYTES_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction memory
// and keeps the core in reset until the whole image has been written and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_csum,
    output logic              cpu_resetn,
    output state_e            dbg_state
);

    // Handshake: a byte moves on a rising edge when s_valid && s_ready.
    // s_ready depends on state only; the source holds s_data while stalled.

    state_e              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          xor_q, xor_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                err_len_q, err_len_d;
    logic                err_csum_q, err_csum_d;

    logic                xfer;
    logic [LEN_W-1:0]    len_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_len_q  <= 1'b0;
            err_csum_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_len_q  <= err_len_d;
            err_csum_q <= err_csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_len_d  = err_len_q;
        err_csum_d = err_csum_q;

        s_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                   (state_q == ST_DATA)   || (state_q == ST_CSUM);
        xfer     = s_valid && s_ready;
        len_full = {len_hi_q, s_data};

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    err_len_d  = 1'b0;
                    err_csum_d = 1'b0;
                    xor_d      = '0;
                    addr_d     = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = s_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    rem_d = len_full;
                    if (len_full > LEN_W'(MEM_BYTES)) begin
                        state_d   = ST_ERR;
                        err_len_d = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data;
                    // Counter reaches MEM_BYTES only after the final byte, so wrap is harmless.
                    addr_d  = addr_q + ADDR_W'(1);
                    xor_d   = xor_q ^ s_data;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (s_data == xor_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ERR;
                        err_csum_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_we     = we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = s_ready;
    assign done       = (state_q == ST_DONE);
    assign cpu_resetn = (state_q == ST_DONE);
    assign err_len    = err_len_q;
    assign err_csum   = err_csum_q;
    assign dbg_state  = state_q;

endmodule
